voltage_averager: RTL
=====================

# voltage_averager

Boxcar moving-average and peak-hold stage that consumes the 10-bit ADC voltage samples produced by the SPI front end and sits between that front end and the LED/display logic. Each accepted sample goes into a circular history of 2^LOG2_DEPTH entries. A running sum is updated incrementally, and a registered average is produced one cycle later. A separate peak register tracks the largest sample since the last clear.

## Interface
- WIDTH, 10: sample width in bits.
- LOG2_DEPTH, 3: log2 of window length; DEPTH = 2^LOG2_DEPTH (default 8).
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe; sample is accepted on any cycle it is high.
- sample  input  WIDTH  unsigned ADC code.
- peak_clear  input  1  clears peak hold.
- avg_valid  output  1  pulses one cycle after each accepted sample.
- avg  output  WIDTH  windowed mean, unsigned.
- primed  output  1  high once DEPTH samples have been accepted since reset.
- peak  output  WIDTH  maximum sample since reset or last peak_clear.

## Operation
- Reset clears everything: all history entries, wr_ptr, fill count, sum, avg, avg_valid, primed and peak are 0. State is EMPTY.
- States:
  - EMPTY: no samples yet.
  - FILLING: 1 to DEPTH-1 samples accepted.
  - PRIMED: DEPTH or more samples accepted.
  - EMPTY → FILLING on the first accepted sample. If DEPTH = 1, go directly EMPTY → PRIMED.
  - FILLING → PRIMED on the DEPTH-th accepted sample.
  - PRIMED is terminal until reset.
- Per accepted sample:
  - oldest = history[wr_ptr], read before the write.
  - history[wr_ptr] ← sample.
  - wr_ptr ← wr_ptr + 1, wrapping mod DEPTH naturally.
  - sum ← sum + sample − oldest.
- sum is WIDTH+LOG2_DEPTH bits wide, unsigned. It cannot overflow or underflow, because history starts at zero.
- avg ← (sum + sample − oldest) >> LOG2_DEPTH. This is truncating division. It is registered together with the sum update.
- Before PRIMED, avg is computed over a zero-padded window and therefore reads low. This is intended; consumers gate on primed.
- Fill counter saturates at DEPTH. primed = (state == PRIMED).
- Peak update:
  - On an accepted sample, peak ← max(peak, sample).
  - On peak_clear without a sample, peak ← 0.
  - On peak_clear and sample_valid in the same cycle, peak ← sample.
- sample_valid held high for consecutive cycles means one sample per cycle. Full throughput, no back-pressure.
- Cycles with sample_valid low leave all state unchanged. avg_valid is 0 on those cycles.

## Timing
- sample_valid high at edge n → at edge n+1, avg_valid = 1 and avg includes that sample.
- Latency is 1 cycle; throughput is 1 sample/cycle.
- primed rises on the same edge as the avg_valid for the DEPTH-th sample.
- peak updates on edge n+1, independent of avg_valid.
- avg holds its value between pulses.
- Asynchronous reset asserted mid-stream:
  - Outputs go to 0 immediately.
  - A sample strobed in the reset cycle is discarded.
  - The first sample after reset deassertion is treated as sample #1.

## Structure
- Package voltage_pkg:
  - ADC_WIDTH = 10.
  - Default LOG2_DEPTH = 3.
  - avg_state_t enum {EMPTY, FILLING, PRIMED}.
- Sub-module sample_ring: DEPTH×WIDTH register array with wr_ptr.
  - Write-enable input.
  - Combinational read of the entry at wr_ptr (the oldest entry).
  - Async reset to zero.
- Sum, state, average and peak logic live in voltage_averager.

## Test plan
- Reset check: assert reset, then release; no stimulus → avg=0, peak=0, primed=0, avg_valid=0.
- Fill: 8 back-to-back samples of 800.
  - avg_valid each cycle.
  - avg = 100, 200, …, 800.
  - primed rises with the 8th result only.
- Wrap-around: after the fill, 8 samples of 0, spaced 3 cycles apart.
  - avg = 700, 600, …, 0.
  - primed stays 1.
  - avg holds between pulses.
- Full scale: 8 samples of 1023 → avg = 1023 (sum 8184), no overflow.
  - Then one sample of 1015 → avg = 1022.
- Peak: samples 100, 900, 300 → peak = 900.
  - peak_clear alone → peak = 0.
  - peak_clear together with sample 50 → peak = 50.
- Reset mid-operation: 5 samples of 512, then assert reset for 2 cycles while strobing sample_valid.
  - Outputs read 0 during reset.
  - Next 8 samples of 512 → avg reaches 512 and primed rises only on the 8th.

Source files
------------

// File: rtl/voltage_pkg.sv
// Shared constants and state encoding for the ADC moving-average / peak-hold stage.
package voltage_pkg;

    localparam int ADC_WIDTH          = 10;
    localparam int LOG2_DEPTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        PRIMED  = 2'd2
    } avg_state_t;

endpackage : voltage_pkg

// File: rtl/voltage_averager_if.sv
// Sample-in / result-out bundle between the SPI front end, the averager and the display logic.
interface voltage_averager_if
    import voltage_pkg::*;
#(
    parameter int WIDTH = ADC_WIDTH
) ();

    logic             sample_valid;
    logic [WIDTH-1:0] sample;
    logic             peak_clear;
    logic             avg_valid;
    logic [WIDTH-1:0] avg;
    logic             primed;
    logic [WIDTH-1:0] peak;

    modport master (
        output sample_valid,
        output sample,
        output peak_clear,
        input  avg_valid,
        input  avg,
        input  primed,
        input  peak
    );

    modport slave (
        input  sample_valid,
        input  sample,
        input  peak_clear,
        output avg_valid,
        output avg,
        output primed,
        output peak
    );

endinterface : voltage_averager_if

// File: rtl/voltage_averager_sample_ring.sv
// Circular sample history; oldest_o is the entry about to be overwritten by the next write.
module sample_ring
    import voltage_pkg::*;
#(
    parameter int WIDTH      = ADC_WIDTH,
    parameter int LOG2_DEPTH = LOG2_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] oldest_o
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Explicit wrap keeps the single-entry configuration pinned at index 0.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_en_i) begin
            if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
                wr_ptr_d = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign oldest_o = mem_q[wr_ptr_q];

endmodule : sample_ring

// File: rtl/voltage_averager.sv
// Boxcar moving average over the last 2^LOG2_DEPTH ADC samples plus a clearable peak hold.
module voltage_averager
    import voltage_pkg::*;
#(
    parameter int WIDTH      = ADC_WIDTH,
    parameter int LOG2_DEPTH = LOG2_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    voltage_averager_if.slave   bus
);

    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int SUM_W  = WIDTH + LOG2_DEPTH;
    localparam int FILL_W = LOG2_DEPTH + 1;

    function automatic logic [WIDTH-1:0] max_code(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic             accept;
    logic [WIDTH-1:0] oldest;
    logic [SUM_W-1:0] sum_upd;

    logic [SUM_W-1:0]  sum_q,       sum_d;
    logic [WIDTH-1:0]  avg_q,       avg_d;
    logic              avg_valid_q, avg_valid_d;
    logic [WIDTH-1:0]  peak_q,      peak_d;
    logic [FILL_W-1:0] fill_q,      fill_d;
    avg_state_t        state_q,     state_d;

    assign accept = bus.sample_valid;

    sample_ring #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (accept),
        .wr_data_i (bus.sample),
        .oldest_o  (oldest)
    );

    // History starts at zero, so the running sum never leaves [0, DEPTH*(2^WIDTH-1)].
    assign sum_upd = sum_q + SUM_W'(bus.sample) - SUM_W'(oldest);

    always_comb begin
        sum_d       = sum_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        fill_d      = fill_q;
        if (accept) begin
            sum_d       = sum_upd;
            avg_d       = WIDTH'(sum_upd >> LOG2_DEPTH);
            avg_valid_d = 1'b1;
            if (fill_q != FILL_W'(DEPTH)) begin
                fill_d = fill_q + FILL_W'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            sum_d       = sum_q;
            avg_d       = avg_q;
            avg_valid_d = 1'b0;
            fill_d      = fill_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = (DEPTH == 1) ? PRIMED : FILLING;
                end else begin
                    state_d = EMPTY;
                end
            end
            FILLING: begin
                if (accept && (fill_q == FILL_W'(DEPTH - 1))) begin
                    state_d = PRIMED;
                end else begin
                    state_d = FILLING;
                end
            end
            PRIMED: begin
                state_d = PRIMED;
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // A sample arriving with a clear restarts the hold from that sample.
    always_comb begin
        peak_d = peak_q;
        if (accept && bus.peak_clear) begin
            peak_d = bus.sample;
        end else if (accept) begin
            peak_d = max_code(peak_q, bus.sample);
        end else if (bus.peak_clear) begin
            peak_d = '0;
        end else begin
            peak_d = peak_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            peak_q      <= '0;
            fill_q      <= '0;
            state_q     <= EMPTY;
        end else begin
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            peak_q      <= peak_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
        end
    end

    assign bus.avg       = avg_q;
    assign bus.avg_valid = avg_valid_q;
    assign bus.peak      = peak_q;
    assign bus.primed    = (state_q == PRIMED);

endmodule : voltage_averager
